// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, hands it to decode, waits for commit.
// Optional IFU_PERF_EN adds fetch/stall performance counters.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        commit_valid,
  input  logic [31:0] commit_next_pc,
  output logic        fetch_fault
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fault_q, fault_d;
`ifdef IFU_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

  // Next-state and datapath; handshake outputs are registered copies of the next state.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
`ifdef IFU_PERF_EN
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
`ifdef IFU_PERF_EN
        else stall_cnt_d = stall_cnt_q + 32'd1;
`endif
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_pc_d = pc_q;
          if (imem_rsp_err) begin
            state_d = FAULT;
          end else begin
            inst_d  = imem_rsp_data;
            state_d = HOLD;
`ifdef IFU_PERF_EN
            fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
          end
        end
`ifdef IFU_PERF_EN
        else stall_cnt_d = stall_cnt_q + 32'd1;
`endif
      end
      HOLD: if (inst_ready) state_d = EXEC;
      EXEC: begin
        if (commit_valid) begin
          // A misaligned target faults without disturbing the PC.
          if (commit_next_pc[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            pc_d    = commit_next_pc;
            state_d = REQ;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    req_valid_d  = (state_d == REQ);
    inst_valid_d = (state_d == HOLD);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_pc_q    <= RESET_PC;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
`ifdef IFU_PERF_EN
      fetch_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      fault_q      <= fault_d;
`ifdef IFU_PERF_EN
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
`endif
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_fault    = fault_q;
`ifdef IFU_PERF_EN
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for ifu: fetch loop timing, stalls, ignored inputs, faults and reset mid-fetch.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid;
  logic [31:0] commit_next_pc;
  logic        fetch_fault;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_req_cyc;

  ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .commit_valid(commit_valid), .commit_next_pc(commit_next_pc),
    .fetch_fault(fetch_fault)
`ifdef IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hs(input string tag, input logic rv, input logic iv, input logic ff);
    chk({tag, ".req_valid"}, 32'(imem_req_valid), 32'(rv));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(iv));
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(ff));
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0; commit_valid = 1'b0; commit_next_pc = 32'd0;
    tick(); tick();
    chk_hs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.addr", imem_req_addr, 32'h8000_0000);
    chk("reset.inst_pc", inst_pc, 32'h8000_0000);
    chk("reset.inst", inst, 32'h0);

    // Basic 4-cycle loop
    rst = 1'b0;
    chk_hs("idle", 1'b0, 1'b0, 1'b0);
    tick();
    chk_hs("req0", 1'b1, 1'b0, 1'b0);
    chk("req0.addr", imem_req_addr, 32'h8000_0000);
    first_req_cyc = cyc;
    imem_req_ready = 1'b1;
    tick();
    chk_hs("wait0", 1'b0, 1'b0, 1'b0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    chk_hs("hold0", 1'b0, 1'b1, 1'b0);
    chk("hold0.inst", inst, 32'h0000_0013);
    chk("hold0.inst_pc", inst_pc, 32'h8000_0000);
    imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    tick();
    chk_hs("exec0", 1'b0, 1'b0, 1'b0);
    inst_ready = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h8000_0004;
    tick();
    commit_valid = 1'b0;
    chk_hs("req1", 1'b1, 1'b0, 1'b0);
    chk("req1.addr", imem_req_addr, 32'h8000_0004);
    chk("loop.cycles", 32'(cyc - first_req_cyc), 32'd4);

    // Request stall, then decode stall with a spurious commit in HOLD
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_hs("reqstall", 1'b1, 1'b0, 1'b0);
      chk("reqstall.addr", imem_req_addr, 32'h8000_0004);
    end
    imem_req_ready = 1'b1;
    tick();
    chk_hs("wait1", 1'b0, 1'b0, 1'b0);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    tick();
    imem_rsp_valid = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_hs("decstall", 1'b0, 1'b1, 1'b0);
      chk("decstall.inst", inst, 32'h0010_0093);
      chk("decstall.inst_pc", inst_pc, 32'h8000_0004);
      chk("decstall.addr", imem_req_addr, 32'h8000_0004);
    end
    commit_valid = 1'b0; inst_ready = 1'b1;
    tick();
    chk_hs("exec1", 1'b0, 1'b0, 1'b0);
`ifdef IFU_PERF_EN
    chk("perf.stall", perf_stall_cnt, 32'd3);
    chk("perf.fetch", perf_fetch_cnt, 32'd2);
`endif
    inst_ready = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h8000_0100;
    tick();
    commit_valid = 1'b0;
    chk_hs("req2", 1'b1, 1'b0, 1'b0);
    chk("req2.addr", imem_req_addr, 32'h8000_0100);

    // Spurious response in REQ is ignored
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1;
    tick();
    chk_hs("spurious", 1'b1, 1'b0, 1'b0);
    chk("spurious.addr", imem_req_addr, 32'h8000_0100);
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_8067;
    tick();
    chk("hold2.inst_pc", inst_pc, 32'h8000_0100);
    imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h8000_00FE;
    tick();
    commit_valid = 1'b0; imem_req_ready = 1'b1;
    chk_hs("misalign", 1'b0, 1'b0, 1'b1);
    chk("misalign.inst_pc", inst_pc, 32'h8000_0100);
    chk("misalign.addr", imem_req_addr, 32'h8000_0100);
    tick(); tick();
    chk_hs("misalign.sticky", 1'b0, 1'b0, 1'b1);

    // Fetch error at 0x8000_0008
    rst = 1'b1; imem_req_ready = 1'b0;
    tick();
    chk_hs("reset2", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; commit_valid = 1'b1; commit_next_pc = 32'h8000_0008;
    tick();
    commit_valid = 1'b0;
    chk("req8.addr", imem_req_addr, 32'h8000_0008);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1;
    tick();
    chk_hs("rsperr", 1'b0, 1'b0, 1'b1);
    chk("rsperr.inst_pc", inst_pc, 32'h8000_0008);
    imem_rsp_err = 1'b0; inst_ready = 1'b1; commit_valid = 1'b1; commit_next_pc = 32'h8000_0010;
    tick(); tick();
    chk_hs("rsperr.sticky", 1'b0, 1'b0, 1'b1);
    imem_rsp_valid = 1'b0; inst_ready = 1'b0; commit_valid = 1'b0;

    // Reset in WAIT; late response must be dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    chk_hs("wait3", 1'b0, 1'b0, 1'b0);
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_hs("midrst", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    chk_hs("postrst.req", 1'b1, 1'b0, 1'b0);
    chk("postrst.addr", imem_req_addr, 32'h8000_0000);
    tick();
    imem_rsp_valid = 1'b0;
    chk_hs("postrst.drop", 1'b1, 1'b0, 1'b0);
    chk("postrst.inst", inst, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue npc core. Owns the architectural PC, issues one word fetch at a time to instruction memory over a valid/ready request channel and a valid-only response channel, and presents the fetched instruction with its PC to decode. It takes the next PC back from execute through the `commit_valid` / `commit_next_pc` pair, where `commit_next_pc` is the ALU `next_pc`. It is the producer of the `pc` that the ALU consumes and the consumer of the `next_pc` the ALU produces.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC after reset.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output 32: fetch address, always equal to the PC.
- `imem_rsp_valid` input 1: fetch data valid; single-cycle pulse.
- `imem_rsp_data` input 32: instruction word.
- `imem_rsp_err` input 1: access fault; qualified by `imem_rsp_valid`.
- `inst_valid` output 1: instruction available to decode.
- `inst_ready` input 1: decode accepts the instruction.
- `inst` output 32: held instruction word.
- `inst_pc` output 32: PC of `inst`, which is the `pc` operand seen by the ALU.
- `commit_valid` input 1: execute has resolved the next PC.
- `commit_next_pc` input 32: next PC from the ALU.
- `fetch_fault` output 1: sticky fault flag.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, EXEC, FAULT.
- IDLE: go to REQ unconditionally on the next clock.
- REQ:
  - `imem_req_valid`=1.
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
  - `imem_req_addr` is stable while in REQ.
- WAIT: on `imem_rsp_valid`:
  - If `imem_rsp_err`=1, go to FAULT.
  - Otherwise capture `imem_rsp_data` into `inst` and go to HOLD.
- HOLD:
  - `inst_valid`=1.
  - `inst` and `inst_pc` are stable until `inst_ready`.
  - On the handshake, go to EXEC.
- EXEC: on `commit_valid`:
  - If `commit_next_pc[1:0]`!=0, go to FAULT; the PC is not updated.
  - Otherwise set PC=`commit_next_pc` and go to REQ.
- FAULT:
  - `fetch_fault`=1.
  - All handshake outputs are 0.
  - Exited only by `rst`.
  - `inst_pc` holds the PC of the faulting fetch, or of the instruction whose commit was misaligned.
- Inputs ignored by state:
  - `imem_rsp_valid` outside WAIT.
  - `commit_valid` outside EXEC.
  - `inst_ready` outside HOLD.
- Exactly one fetch is outstanding at a time. There is no prefetch and no speculative PC+4.
- PC arithmetic is 32-bit; wrap-around at 2^32 is permitted and not flagged.

## Timing
- Reset values while `rst`=1:
  - State: IDLE.
  - PC and `inst_pc`: `RESET_PC`.
  - `inst`: 0.
  - `imem_req_valid`, `inst_valid`, `fetch_fault`: 0.
- After `rst` falls, IDLE holds for one cycle, then `imem_req_valid` rises.
- Request accepted at edge N: the earliest valid response is sampled at edge N+1. A response in the same cycle as the request is not supported.
- Response sampled at edge M: `inst_valid`=1 from edge M.
- Decode handshake at edge K: `commit_valid` is honoured from edge K+1.
- Commit at edge J: `imem_req_valid`=1 with the new address from edge J.
- Best-case loop: 4 cycles per instruction, one each in REQ, WAIT, HOLD and EXEC.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.
- `rst` asserted mid-transaction: return to IDLE immediately. Any in-flight response arriving after reset is dropped, because IDLE and REQ ignore `imem_rsp_valid`.

## Configuration
- `IFU_PERF_EN` defined: adds output `perf_fetch_cnt` 32 and output `perf_stall_cnt` 32.
  - `perf_fetch_cnt` increments on each error-free response.
  - `perf_stall_cnt` increments on every cycle in REQ with `imem_req_ready`=0, and on every cycle in WAIT with `imem_rsp_valid`=0.
  - Both reset to 0, wrap at 2^32, and freeze in FAULT.
- `IFU_PERF_EN` undefined: these ports and counters do not exist; the rest of the behaviour is identical.

## Test plan
- Reset release, memory ready immediately with a 1-cycle response, decode ready, commit 0x8000_0004 → `imem_req_addr`=0x8000_0000, then `inst_valid` with `inst_pc`=0x8000_0000, then the next request at 0x8000_0004 exactly 4 cycles after the first.
- Hold `imem_req_ready`=0 for 3 cycles, then `inst_ready`=0 for 2 cycles → `imem_req_valid` and `imem_req_addr` stable during the stall; `inst`/`inst_pc` stable while `inst_valid`=1. With `IFU_PERF_EN`, `perf_stall_cnt`=3.
- Commit a jalr-style target 0x8000_0100, then 0x8000_00FE → the first fetch goes to 0x8000_0100; the second commit sets `fetch_fault`=1, with no further requests and `inst_pc`=0x8000_0100.
- Response with `imem_rsp_err`=1 at fetch 0x8000_0008 → `fetch_fault`=1, `inst_valid` never asserts, and the flag holds until `rst`.
- Spurious `imem_rsp_valid` during REQ, and `commit_valid` during HOLD → both ignored, with no state or PC change.
- Assert `rst` in WAIT and deliver the response 1 cycle after release → response dropped, and the first request after reset is at `RESET_PC`.
